// File: rtl/sc_pkt_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_pkt_fifo_if : write/read bus of the packet-mode show-ahead FIFO   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sc_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_eop_i;
  logic                  wr_i;
  logic                  wr_drop_i;
  logic                  wr_full_o;
  logic                  wr_almost_full_o;
  logic                  overflow_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_eop_o;
  logic                  rd_i;
  logic                  rd_empty_o;
  logic                  rd_almost_empty_o;
  logic [ADDR_WIDTH:0]   used_words_o;
  logic [ADDR_WIDTH:0]   pkt_cnt_o;

  modport master (
    output wr_data_i, wr_eop_i, wr_i, wr_drop_i, rd_i,
    input  wr_full_o, wr_almost_full_o, overflow_o, rd_data_o, rd_eop_o,
           rd_empty_o, rd_almost_empty_o, used_words_o, pkt_cnt_o
  );

  modport slave (
    input  wr_data_i, wr_eop_i, wr_i, wr_drop_i, rd_i,
    output wr_full_o, wr_almost_full_o, overflow_o, rd_data_o, rd_eop_o,
           rd_empty_o, rd_almost_empty_o, used_words_o, pkt_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sc_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_pkt_fifo : single-clock show-ahead FIFO, packet store-and-forward |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sc_pkt_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 16,
  parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
  parameter int PKT_MODE     = 1,
  parameter int AFULL_LVL    = WORDS_AMOUNT - 2,
  parameter int AEMPTY_LVL   = 2
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  sc_pkt_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] C_WORDS  = WORDS_AMOUNT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_AFULL  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = AEMPTY_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_ONE    = 1;

  logic [DATA_WIDTH:0]   mem [WORDS_AMOUNT];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cm_ptr_q, cm_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   pkt_cnt_q, pkt_cnt_d;
  logic                  dao_q, dao_d;
  logic                  bad_q, bad_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_eop_q;

  logic                  w_drop;
  logic                  w_commit_all;
  logic                  w_bad_en;
  logic [ADDR_WIDTH:0]   w_occ;
  logic [ADDR_WIDTH:0]   w_used;
  logic                  w_full;
  logic                  w_ovf_now;
  logic                  w_bad_now;
  logic                  w_abort;
  logic                  w_wr_req;
  logic                  w_dim;
  logic                  w_rd_req;
  logic                  w_rd_en;
  logic                  w_inc;
  logic                  w_dec;

  // Streaming mode commits every word and never enters the discard state.
  if (PKT_MODE != 0) begin : g_pkt
    assign w_drop       = bus.wr_drop_i;
    assign w_commit_all = 1'b0;
    assign w_bad_en     = 1'b1;
  end else begin : g_stream
    assign w_drop       = 1'b0;
    assign w_commit_all = 1'b1;
    assign w_bad_en     = 1'b0;
  end

  assign w_occ     = wr_ptr_q - rd_ptr_q + {{ADDR_WIDTH{1'b0}}, dao_q};
  assign w_used    = cm_ptr_q - rd_ptr_q + {{ADDR_WIDTH{1'b0}}, dao_q};
  assign w_full    = (w_occ == C_WORDS);
  assign w_ovf_now = bus.wr_i & w_full;
  assign w_bad_now = w_bad_en & (bad_q | w_ovf_now);
  // A corrupted packet ends at its eop (or an explicit drop) and is rolled back.
  assign w_abort   = w_bad_now & ((bus.wr_i & bus.wr_eop_i) | w_drop);
  assign w_wr_req  = bus.wr_i & ~w_full & ~w_drop & ~bad_q;

  assign w_dim     = (cm_ptr_q != rd_ptr_q);
  assign w_rd_req  = bus.rd_i & dao_q;
  assign w_rd_en   = w_dim & (~dao_q | w_rd_req);
  assign w_inc     = w_wr_req & bus.wr_eop_i;
  assign w_dec     = w_rd_req & rd_eop_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    dao_d     = dao_q;
    bad_d     = w_bad_now;
    ovf_d     = w_ovf_now;

    if (w_abort) begin
      wr_ptr_d = cm_ptr_q;
      bad_d    = 1'b0;
    end else if (w_drop) begin
      wr_ptr_d = cm_ptr_q;
    end else if (w_wr_req) begin
      wr_ptr_d = wr_ptr_q + C_ONE;
      if (w_commit_all | bus.wr_eop_i) begin
        cm_ptr_d = wr_ptr_q + C_ONE;
      end
    end

    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end
    if (w_rd_req | ~dao_q) begin
      dao_d = w_dim;
    end

    case ({w_inc, w_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + C_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - C_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      dao_q     <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_eop_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      dao_q     <= dao_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
      if (w_rd_en) begin
        {rd_eop_q, rd_data_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_req) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.wr_eop_i, bus.wr_data_i};
    end
  end

  assign bus.wr_full_o         = w_full;
  assign bus.wr_almost_full_o  = (w_occ >= C_AFULL);
  assign bus.overflow_o        = ovf_q;
  assign bus.rd_data_o         = rd_data_q;
  assign bus.rd_eop_o          = rd_eop_q;
  assign bus.rd_empty_o        = ~dao_q;
  assign bus.rd_almost_empty_o = (w_used <= C_AEMPTY);
  assign bus.used_words_o      = w_used;
  assign bus.pkt_cnt_o         = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sc_pkt_fifo : directed bench for packet and streaming FIFO modes  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sc_pkt_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sc_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bp ();
  sc_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bs ();

  sc_pkt_fifo #(.DATA_WIDTH(DW), .WORDS_AMOUNT(16), .PKT_MODE(1)) u_pkt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bp.slave)
  );

  sc_pkt_fifo #(.DATA_WIDTH(DW), .WORDS_AMOUNT(16), .PKT_MODE(0)) u_str (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bs.slave)
  );

  typedef struct {
    logic          wr;
    logic          eop;
    logic          drop;
    logic          rd;
    logic [DW-1:0] data;
    logic          e_empty;
    logic [DW-1:0] e_data;
    logic          e_eop;
    int            e_used;
    int            e_pkt;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic eop, input logic drop, input logic rd,
                              input logic [DW-1:0] d, input logic em, input logic [DW-1:0] ed,
                              input logic ee, input int used, input int pkt);
    vec_t v;
    v.wr = wr; v.eop = eop; v.drop = drop; v.rd = rd; v.data = d;
    v.e_empty = em; v.e_data = ed; v.e_eop = ee; v.e_used = used; v.e_pkt = pkt;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] q [$];
    int budget;

    //          wr eop drp rd  data   | empty data  eop used pkt
    vt[0]  = mk(1, 0, 0, 0, 8'hA1,  1, 8'h00, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 8'hB2,  1, 8'h00, 0, 0, 0);
    vt[2]  = mk(1, 1, 0, 0, 8'hC3,  1, 8'h00, 0, 3, 1);
    vt[3]  = mk(0, 0, 0, 0, 8'h00,  0, 8'hA1, 0, 3, 1);
    vt[4]  = mk(0, 0, 0, 1, 8'h00,  0, 8'hB2, 0, 2, 1);
    vt[5]  = mk(0, 0, 0, 1, 8'h00,  0, 8'hC3, 1, 1, 1);
    vt[6]  = mk(0, 0, 0, 1, 8'h00,  1, 8'h00, 0, 0, 0);
    vt[7]  = mk(1, 0, 0, 0, 8'h11,  1, 8'h00, 0, 0, 0);
    vt[8]  = mk(1, 0, 0, 0, 8'h22,  1, 8'h00, 0, 0, 0);
    vt[9]  = mk(1, 0, 1, 0, 8'h33,  1, 8'h00, 0, 0, 0);
    vt[10] = mk(1, 1, 0, 0, 8'h44,  1, 8'h00, 0, 1, 1);
    vt[11] = mk(0, 0, 0, 0, 8'h00,  0, 8'h44, 1, 1, 1);
    vt[12] = mk(1, 1, 0, 1, 8'h55,  1, 8'h00, 0, 1, 1);
    vt[13] = mk(0, 0, 0, 0, 8'h00,  0, 8'h55, 1, 1, 1);
    vt[14] = mk(0, 0, 0, 1, 8'h00,  1, 8'h00, 0, 0, 0);
    vt[15] = mk(0, 0, 0, 1, 8'h00,  1, 8'h00, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 8'h00,  1, 8'h00, 0, 0, 0);

    bp.wr_data_i = '0; bp.wr_eop_i = 0; bp.wr_i = 0; bp.wr_drop_i = 0; bp.rd_i = 0;
    bs.wr_data_i = '0; bs.wr_eop_i = 0; bs.wr_i = 0; bs.wr_drop_i = 0; bs.rd_i = 0;

    step();
    step();
    chk("rst_empty",  32'(bp.rd_empty_o), 1);
    chk("rst_aempty", 32'(bp.rd_almost_empty_o), 1);
    chk("rst_full",   32'(bp.wr_full_o), 0);
    chk("rst_afull",  32'(bp.wr_almost_full_o), 0);
    chk("rst_used",   32'(bp.used_words_o), 0);
    chk("rst_pkt",    32'(bp.pkt_cnt_o), 0);
    chk("rst_data",   32'(bp.rd_data_o), 0);
    chk("rst_ovf",    32'(bp.overflow_o), 0);
    rst_i = 1'b0;
    step();

    // Packet mode: basic packet, drop with concurrent write, commit+pop, pop while empty
    for (int i = 0; i < NV; i++) begin
      bp.wr_i = vt[i].wr; bp.wr_eop_i = vt[i].eop; bp.wr_drop_i = vt[i].drop;
      bp.rd_i = vt[i].rd; bp.wr_data_i = vt[i].data;
      step();
      chk($sformatf("v%0d_empty", i), 32'(bp.rd_empty_o), 32'(vt[i].e_empty));
      chk($sformatf("v%0d_used", i), 32'(bp.used_words_o), 32'(vt[i].e_used));
      chk($sformatf("v%0d_pkt", i), 32'(bp.pkt_cnt_o), 32'(vt[i].e_pkt));
      chk($sformatf("v%0d_aempty", i), 32'(bp.rd_almost_empty_o), 32'(vt[i].e_used <= 2));
      chk($sformatf("v%0d_afull", i), 32'(bp.wr_almost_full_o), 0);
      if (!vt[i].e_empty) begin
        chk($sformatf("v%0d_data", i), 32'(bp.rd_data_o), 32'(vt[i].e_data));
        chk($sformatf("v%0d_eop", i), 32'(bp.rd_eop_o), 32'(vt[i].e_eop));
      end
    end
    bp.wr_i = 0; bp.wr_eop_i = 0; bp.wr_drop_i = 0; bp.rd_i = 0;

    // Packet mode: 20-word packet overflows a 16-word FIFO and is discarded
    for (int i = 0; i < 20; i++) begin
      bp.wr_i = 1; bp.wr_data_i = 8'(i); bp.wr_eop_i = (i == 19);
      step();
      if (i == 12) chk("ovp_afull13", 32'(bp.wr_almost_full_o), 0);
      if (i == 13) chk("ovp_afull14", 32'(bp.wr_almost_full_o), 1);
      if (i == 14) chk("ovp_full15", 32'(bp.wr_full_o), 0);
      if (i == 15) chk("ovp_full16", 32'(bp.wr_full_o), 1);
      if (i == 15) chk("ovp_ovf16", 32'(bp.overflow_o), 0);
      if (i == 16) chk("ovp_ovf17", 32'(bp.overflow_o), 1);
      if (i < 19)  chk($sformatf("ovp_empty%0d", i), 32'(bp.rd_empty_o), 1);
    end
    chk("ovp_used_end", 32'(bp.used_words_o), 0);
    chk("ovp_full_end", 32'(bp.wr_full_o), 0);
    chk("ovp_afull_end", 32'(bp.wr_almost_full_o), 0);
    chk("ovp_pkt_end", 32'(bp.pkt_cnt_o), 0);
    bp.wr_i = 0; bp.wr_eop_i = 0;
    step();
    chk("ovp_ovf_clr", 32'(bp.overflow_o), 0);
    chk("ovp_empty_clr", 32'(bp.rd_empty_o), 1);
    bp.wr_i = 1; bp.wr_data_i = 8'h5A; bp.wr_eop_i = 0;
    step();
    bp.wr_data_i = 8'h5B; bp.wr_eop_i = 1;
    step();
    bp.wr_i = 0; bp.wr_eop_i = 0;
    step();
    chk("ovp_recover_data", 32'(bp.rd_data_o), 32'h5A);
    chk("ovp_recover_used", 32'(bp.used_words_o), 2);
    bp.rd_i = 1;
    step();
    step();
    bp.rd_i = 0;
    chk("ovp_recover_drain", 32'(bp.rd_empty_o), 1);

    // Streaming mode: fill to capacity, then sustained read+write
    for (int i = 0; i < 16; i++) begin
      bs.wr_i = 1; bs.wr_data_i = 8'h80 + 8'(i);
      q.push_back(8'h80 + 8'(i));
      step();
      if (i == 12) chk("str_afull13", 32'(bs.wr_almost_full_o), 0);
      if (i == 13) chk("str_afull14", 32'(bs.wr_almost_full_o), 1);
      if (i == 14) chk("str_full15", 32'(bs.wr_full_o), 0);
    end
    bs.wr_i = 0;
    chk("str_full16", 32'(bs.wr_full_o), 1);
    chk("str_used16", 32'(bs.used_words_o), 16);
    chk("str_pkt16", 32'(bs.pkt_cnt_o), 0);
    chk("str_head0", 32'(bs.rd_data_o), 32'(q[0]));
    bs.rd_i = 1;
    void'(q.pop_front());
    step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("str_rw_empty%0d", i), 32'(bs.rd_empty_o), 0);
      chk($sformatf("str_rw_data%0d", i), 32'(bs.rd_data_o), 32'(q[0]));
      bs.rd_i = 1; bs.wr_i = 1; bs.wr_data_i = 8'h10 + 8'(i);
      void'(q.pop_front());
      q.push_back(8'h10 + 8'(i));
      step();
      chk($sformatf("str_rw_ovf%0d", i), 32'(bs.overflow_o), 0);
    end
    bs.wr_i = 0;
    budget = 40;
    while (q.size() > 0 && budget > 0) begin
      chk("str_drain_data", 32'(bs.rd_data_o), 32'(q[0]));
      bs.rd_i = 1;
      void'(q.pop_front());
      step();
      budget--;
    end
    if (q.size() > 0) chk("str_drain_budget", 32'(q.size()), 0);
    bs.rd_i = 0;
    chk("str_drain_empty", 32'(bs.rd_empty_o), 1);
    chk("str_drain_used", 32'(bs.used_words_o), 0);

    // Packet mode: asynchronous reset with 5 committed words and an open packet
    for (int i = 0; i < 7; i++) begin
      bp.wr_i = 1; bp.wr_data_i = 8'hE0 + 8'(i); bp.wr_eop_i = (i == 4);
      step();
    end
    bp.wr_i = 0; bp.wr_eop_i = 0;
    chk("arst_pre_used", 32'(bp.used_words_o), 5);
    chk("arst_pre_pkt", 32'(bp.pkt_cnt_o), 1);
    chk("arst_pre_empty", 32'(bp.rd_empty_o), 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_empty", 32'(bp.rd_empty_o), 1);
    chk("arst_used", 32'(bp.used_words_o), 0);
    chk("arst_pkt", 32'(bp.pkt_cnt_o), 0);
    chk("arst_data", 32'(bp.rd_data_o), 0);
    chk("arst_full", 32'(bp.wr_full_o), 0);
    chk("arst_afull", 32'(bp.wr_almost_full_o), 0);
    step();
    rst_i = 1'b0;
    step();
    step();
    step();
    chk("arst_post_empty", 32'(bp.rd_empty_o), 1);
    chk("arst_post_used", 32'(bp.used_words_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
